// File: rtl/ion_pkg.sv
// ============================================================================
// Module : ion_pkg
// Brief  : Shared FSM encoding and fixed-point saturation helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ion_pkg;

  // Helpers work on a 64-bit signed carrier; callers size-cast the result.
  localparam int c_calc_w = 64;

  typedef logic [1:0] state_t;
  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_calc  = 2'd1;
  localparam state_t c_st_drain = 2'd2;
  localparam state_t c_st_done  = 2'd3;

  function automatic logic signed [c_calc_w-1:0] q_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [c_calc_w-1:0] q_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic sat_ovf(input logic signed [c_calc_w-1:0] x, input int w);
    return (x > q_max(w)) || (x < q_min(w));
  endfunction

  function automatic logic signed [c_calc_w-1:0] sat_clip(input logic signed [c_calc_w-1:0] x,
                                                          input int w);
    if (x > q_max(w)) return q_max(w);
    if (x < q_min(w)) return q_min(w);
    return x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ion_mac_stage.sv
// ============================================================================
// Module : ion_mac_stage
// Brief  : One channel term G*(V-E) >>> FRAC, saturated to W bits (W <= 31).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ion_mac_stage
  import ion_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                en,
  input  logic signed [W-1:0] g,
  input  logic signed [W-1:0] v,
  input  logic signed [W-1:0] e,
  output logic signed [W-1:0] prod,
  output logic                sat
);

  logic signed [W:0]            w_diff;
  logic signed [2*W:0]          w_g_ext;
  logic signed [2*W:0]          w_d_ext;
  logic signed [2*W:0]          w_full;
  logic signed [2*W:0]          w_shift;
  logic signed [c_calc_w-1:0]   w_wide;

  assign w_diff  = $signed({v[W-1], v}) - $signed({e[W-1], e});
  assign w_g_ext = {{(W+1){g[W-1]}}, g};
  assign w_d_ext = {{W{w_diff[W]}}, w_diff};
  assign w_full  = w_g_ext * w_d_ext;
  // Arithmetic shift floors toward minus infinity, no rounding.
  assign w_shift = w_full >>> FRAC;
  assign w_wide  = {{(c_calc_w-2*W-1){w_shift[2*W]}}, w_shift};

  assign prod = en ? W'(sat_clip(w_wide, W)) : '0;
  assign sat  = en && sat_ovf(w_wide, W);

endmodule

`default_nettype wire

// File: rtl/ionic_current_unit.sv
// ============================================================================
// Module : ionic_current_unit
// Brief  : Sequential sum of NCH channel currents G_k*(V-E_k), one per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ionic_current_unit
  import ion_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int NCH  = 4,
  localparam int AW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        V,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [W-1:0]        cfg_data,
  output logic                cfg_err,
  input  logic [NCH-1:0]      ch_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        I_total,
  output logic                sat
);

  localparam int            ACCW   = W + $clog2(NCH) + 1;
  localparam logic [AW-1:0] c_last = AW'(NCH - 1);

  state_t                  r_state, w_next;
  logic [AW-1:0]           r_k;
  logic signed [W-1:0]     r_v;
  logic [NCH-1:0]          r_en;
  logic signed [W-1:0]     r_g [NCH];
  logic signed [W-1:0]     r_e [NCH];
  logic signed [W-1:0]     r_prod;
  logic                    r_prod_sat;
  logic signed [ACCW-1:0]  r_acc;
  logic                    r_sat;
  logic [W-1:0]            r_i_total;
  logic                    r_sat_out;
  logic                    r_out_valid;
  logic                    r_cfg_err;

  logic signed [W-1:0]     w_prod;
  logic                    w_prod_sat;
  logic signed [c_calc_w-1:0] w_acc_wide;
  logic                    w_idle, w_accept, w_accum, w_load_out, w_cfg_ok;

  ion_mac_stage #(.W(W), .FRAC(FRAC)) u_mac (
    .en   (r_en[r_k]),
    .g    (r_g[r_k]),
    .v    (r_v),
    .e    (r_e[r_k]),
    .prod (w_prod),
    .sat  (w_prod_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (in_valid) w_next = c_st_calc;
      c_st_calc:  if (r_k == c_last) w_next = c_st_drain;
      c_st_drain: w_next = c_st_done;
      c_st_done:  if (r_out_valid && out_ready) w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_idle     = (r_state == c_st_idle);
    w_accept   = w_idle && in_valid;
    w_accum    = (r_state == c_st_calc) || (r_state == c_st_drain);
    // First DONE cycle latches the saturated sum; out_valid follows it.
    w_load_out = (r_state == c_st_done) && !r_out_valid;
    w_cfg_ok   = (32'(cfg_addr) < NCH);
  end

  assign w_acc_wide = {{(c_calc_w-ACCW){r_acc[ACCW-1]}}, r_acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_v         <= '0;
      r_en        <= '0;
      r_prod      <= '0;
      r_prod_sat  <= 1'b0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_i_total   <= '0;
      r_sat_out   <= 1'b0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_g[i] <= '0;
        r_e[i] <= '0;
      end
    end else begin
      r_cfg_err <= cfg_we && !(w_idle && w_cfg_ok);
      if (cfg_we && w_idle && w_cfg_ok) begin
        if (cfg_sel) r_e[cfg_addr] <= cfg_data;
        else         r_g[cfg_addr] <= cfg_data;
      end

      if (w_accept) begin
        r_v        <= V;
        r_en       <= ch_en;
        r_k        <= '0;
        r_prod     <= '0;
        r_prod_sat <= 1'b0;
        r_acc      <= '0;
        r_sat      <= 1'b0;
      end

      if (r_state == c_st_calc) begin
        r_prod     <= w_prod;
        r_prod_sat <= w_prod_sat;
        r_k        <= (r_k == c_last) ? '0 : r_k + AW'(1);
      end

      // Each product is summed one cycle after it was registered.
      if (w_accum) begin
        r_acc <= r_acc + {{(ACCW-W){r_prod[W-1]}}, r_prod};
        r_sat <= r_sat | r_prod_sat;
      end

      if (w_load_out) begin
        r_i_total   <= W'(sat_clip(w_acc_wide, W));
        r_sat_out   <= r_sat | sat_ovf(w_acc_wide, W);
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_idle;
  assign out_valid = r_out_valid;
  assign I_total   = r_i_total;
  assign sat       = r_sat_out;
  assign cfg_err   = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_ionic_current_unit.sv
// ============================================================================
// Module : tb_ionic_current_unit
// Brief  : Directed vectors with hand-computed currents for ionic_current_unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ionic_current_unit;

  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int NCH  = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  V;
  logic          cfg_we;
  logic          cfg_sel;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic          cfg_err;
  logic [NCH-1:0] ch_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  I_total;
  logic          sat;

  int n_cmp = 0;
  int n_bad = 0;

  ionic_current_unit #(.W(W), .FRAC(FRAC), .NCH(NCH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .V(V),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready), .I_total(I_total), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic sel, input logic [AW-1:0] addr, input logic [W-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic accept(input logic [W-1:0] v, input logic [NCH-1:0] en);
    in_valid = 1'b1; V = v; ch_en = en;
    tick;
    in_valid = 1'b0;
  endtask

  // Walk to the result edge; 'done' counts edges already spent after acceptance.
  task automatic finish_sample(input string tag, input int done,
                               input logic [W-1:0] exp_i, input logic exp_sat);
    for (int i = done + 1; i <= NCH + 1; i++) tick;
    chk({tag, "_ov_early"}, 32'(out_valid), 32'd0);
    tick;
    chk({tag, "_ov_edge"}, 32'(out_valid), 32'd1);
    chk({tag, "_itotal"}, 32'(I_total), 32'(exp_i));
    chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    chk({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_inrdy_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_ov;
    rst = 1'b1; in_valid = 1'b0; V = '0; cfg_we = 1'b0; cfg_sel = 1'b0;
    cfg_addr = '0; cfg_data = '0; ch_en = '0; out_ready = 1'b0;
    tick; tick;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_itotal", 32'(I_total), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;
    tick;

    // Leak channel: 0.30 * 5.0 mV -> 0x0181
    cfg_write(1'b0, 2'd0, 16'h004D);
    cfg_write(1'b1, 2'd0, 16'hBA00);
    chk("cfg_idle_noerr", 32'(cfg_err), 32'd0);
    accept(16'hBF00, 4'b0001);
    finish_sample("leak", 0, 16'h0181, 1'b0);
    release_out("leak");

    // Second channel; G_1 written in the same cycle the sample is accepted
    cfg_write(1'b1, 2'd1, 16'h3200);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd1; cfg_data = 16'h0100;
    accept(16'hBF00, 4'b0011);
    cfg_we = 1'b0;
    finish_sample("two_ch", 0, 16'h8E81, 1'b0);

    // Backpressure: result held, new offer ignored
    in_valid = 1'b1; V = 16'h1111; ch_en = 4'b1111;
    for (int i = 0; i < 5; i++) tick;
    chk("bp_itotal", 32'(I_total), 32'h8E81);
    chk("bp_ov", 32'(out_valid), 32'd1);
    chk("bp_inrdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    release_out("bp");

    // Config during CALC is dropped with a one-cycle error pulse
    accept(16'hBF00, 4'b0001);
    tick;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd0; cfg_data = 16'h1234;
    tick;
    cfg_we = 1'b0;
    chk("calc_cfg_err_hi", 32'(cfg_err), 32'd1);
    tick;
    chk("calc_cfg_err_lo", 32'(cfg_err), 32'd0);
    finish_sample("calc_cfg", 3, 16'h0181, 1'b0);
    release_out("calc_cfg");
    accept(16'hBF00, 4'b0001);
    finish_sample("g0_kept", 0, 16'h0181, 1'b0);
    release_out("g0_kept");

    // All channels disabled: same latency, zero current
    accept(16'hBF00, 4'b0000);
    finish_sample("none_en", 0, 16'h0000, 1'b0);
    release_out("none_en");

    // Positive per-channel saturation
    cfg_write(1'b0, 2'd0, 16'h7FFF);
    cfg_write(1'b1, 2'd0, 16'h8000);
    accept(16'h7FFF, 4'b0001);
    finish_sample("sat_pos", 0, 16'h7FFF, 1'b1);
    release_out("sat_pos");

    // Negative per-channel saturation
    cfg_write(1'b1, 2'd0, 16'h7FFF);
    accept(16'h8000, 4'b0001);
    finish_sample("sat_neg", 0, 16'h8000, 1'b1);
    release_out("sat_neg");

    // -1 LSB product floors to -1, not 0
    cfg_write(1'b0, 2'd0, 16'h0001);
    cfg_write(1'b1, 2'd0, 16'h0000);
    accept(16'hFFFF, 4'b0001);
    finish_sample("trunc", 0, 16'hFFFF, 1'b0);
    release_out("trunc");

    // Two in-range terms of 0x4000 overflow only in the final sum
    cfg_write(1'b0, 2'd2, 16'h0100);
    cfg_write(1'b1, 2'd2, 16'h8000);
    cfg_write(1'b0, 2'd3, 16'h0100);
    cfg_write(1'b1, 2'd3, 16'h8000);
    accept(16'hC000, 4'b1100);
    finish_sample("sum_sat", 0, 16'h7FFF, 1'b1);
    release_out("sum_sat");

    // Reset in the middle of CALC discards the sample and clears G/E
    accept(16'hBF00, 4'b1111);
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_inrdy", 32'(in_ready), 32'd1);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_itotal", 32'(I_total), 32'd0);
    seen_ov = 1'b0;
    for (int i = 0; i < NCH + 3; i++) begin
      tick;
      seen_ov = seen_ov | out_valid;
    end
    chk("mrst_no_ov", 32'(seen_ov), 32'd0);
    accept(16'h1234, 4'b1111);
    finish_sample("post_rst", 0, 16'h0000, 1'b0);
    release_out("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ionic_current_unit.md
IONIC_CURRENT_UNIT -- requirements
Module: ionic_current_unit

Interface
REQ-001 SHALL have parameter W, default 16, meaning signed fixed-point width of V, E, G and I.
REQ-002 SHALL have parameter FRAC, default 8, meaning fractional bits (Q(W-FRAC).FRAC).
REQ-003 SHALL have parameter NCH, default 4 (>=1), meaning number of conductance channels.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: in_valid  in  1  V sample offered; in_ready  out  1  unit can accept; V  in  W  membrane potential.
REQ-006 SHALL have ports: cfg_we  in  1  config write strobe; cfg_sel  in  1  0=G, 1=E; cfg_addr  in  clog2(NCH)  channel; cfg_data  in  W  value; cfg_err  out  1  write rejected.
REQ-007 SHALL have ports: ch_en  in  NCH  per-channel enable mask, sampled at acceptance.
REQ-008 SHALL have ports: out_valid  out  1  result ready; out_ready  in  1  consumer accepts; I_total  out  W  summed current; sat  out  1  any saturation occurred for this sample.

Function
REQ-009 SHALL compute I_total = sum over enabled k of G_k*(V-E_k), one shared multiplier, one channel per cycle.
REQ-010 SHALL form V-E_k in W+1 bits (no overflow), product in 2W+1 bits, arithmetic shift right by FRAC (truncation toward minus infinity), saturate to W bits per channel.
REQ-011 SHALL accumulate in W+clog2(NCH)+1 bits and saturate the final sum to W bits.
REQ-012 SHALL set sat when any per-channel or final saturation occurs for the sample.
REQ-013 SHALL implement FSM IDLE -> CALC -> DRAIN -> DONE -> IDLE.
REQ-014 IDLE: in_ready=1; on in_valid, register V and ch_en, clear accumulator and sat, go to CALC with channel counter 0.
REQ-015 CALC: register the product of channel counter k each cycle; after k=NCH-1 go to DRAIN.
REQ-016 DRAIN: add the last registered product, go to DONE.
REQ-017 Disabled channels SHALL contribute 0 but still consume their cycle (fixed latency).
REQ-018 out_valid SHALL rise exactly NCH+2 rising edges after the acceptance edge, independent of ch_en.
REQ-019 DONE: out_valid=1, I_total and sat stable until out_valid&&out_ready; then go to IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE; no back-to-back overlap of samples.
REQ-021 cfg_we in IDLE SHALL write G_k or E_k on the next edge; cfg_we in any other state SHALL be dropped and cfg_err pulsed high for one cycle.
REQ-022 cfg_we and in_valid in the same IDLE cycle: the write SHALL take effect; the accepted sample SHALL use the newly written value.

Reset
REQ-023 rst SHALL be synchronous and active-high, taking priority over all other inputs, including mid-computation.
REQ-024 On reset: state IDLE, in_ready=1, out_valid=0, I_total=0, sat=0, cfg_err=0, accumulator 0, all G_k=0, all E_k=0.
REQ-025 A sample in flight at reset SHALL be discarded with no out_valid.

Structure
REQ-026 Fixed-point helpers (saturate function, Q-format constants, FSM state typedef) SHALL live in shared package ion_pkg.
REQ-027 The multiply/shift/saturate stage SHALL be a sub-module named ion_mac_stage; control, register file and accumulator SHALL stay in ionic_current_unit.

Verification
REQ-028 Leak point: G_0=0x004D, E_0=0xBA00, ch_en=0001, V=0xBF00 -> I_total=0x0181, sat=0, out_valid at edge NCH+2.
REQ-029 Two channels: ch0 as above, G_1=0x0100, E_1=0x3200, ch_en=0011, V=0xBF00 -> I_total=0x0181-0x7300=0x8E81, sat=0.
REQ-030 Saturation: G_0=0x7FFF, E_0=0x8000, V=0x7FFF, ch_en=0001 -> I_total=0x7FFF, sat=1.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> I_total stable, in_ready=0, new in_valid ignored; accept after release.
REQ-032 Config during CALC -> cfg_err one-cycle pulse, register unchanged on the next sample.
REQ-033 rst asserted at CALC cycle 2 -> next cycle IDLE, out_valid=0, all G/E=0; a following sample yields I_total=0.
